rr_arbiter_8to3: RTL and testbench

//  Round-robin arbiter that shares one resource among 8 requesters and reports
//  the winner as one-hot plus a 3-bit binary index (the 8-to-3 encoding).

---
 rtl/rr_arbiter_8to3.sv | 135 +++++++++++++
 tb/tb_rr_arbiter_8to3.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8to3.sv
// Round-robin arbiter: 8 requesters share one resource; the winner is reported
// one-hot and as a 3-bit index. Grants end on done, request drop or hold limit.
module rr_arbiter_8to3 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic       gnt_valid,
    output logic [7:0] gnt_onehot,
    output logic [2:0] gnt_idx,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last hold_cnt value a grant may reach before it is force-released.
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD != 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    state_t            state_q,      state_d;
    logic [2:0]        ptr_q,        ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
    logic              gnt_valid_q,  gnt_valid_d;
    logic [7:0]        gnt_onehot_q, gnt_onehot_d;
    logic [2:0]        gnt_idx_q,    gnt_idx_d;
    logic              timeout_q,    timeout_d;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;

    logic owner_req;
    logic hit_limit;
    logic release_now;

    // Rotating priority search: ptr_q has highest priority, wrapping 7 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_req   = req[gnt_idx_q];
        hit_limit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
        release_now = done || !owner_req || hit_limit;
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hold_cnt_d   = hold_cnt_q;
        gnt_valid_d  = gnt_valid_q;
        gnt_onehot_d = gnt_onehot_q;
        gnt_idx_d    = gnt_idx_q;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d      = GRANT;
                    gnt_valid_d  = 1'b1;
                    gnt_idx_d    = win_idx;
                    gnt_onehot_d = 8'(1) << win_idx;
                    hold_cnt_d   = '0;
                    ptr_d        = win_idx + 3'd1;
                end else begin
                    gnt_valid_d  = 1'b0;
                    gnt_idx_d    = '0;
                    gnt_onehot_d = '0;
                end
            end

            GRANT: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (release_now) begin
                    state_d      = IDLE;
                    gnt_valid_d  = 1'b0;
                    gnt_idx_d    = '0;
                    gnt_onehot_d = '0;
                    hold_cnt_d   = '0;
                    // A voluntary release in the same cycle masks the limit.
                    timeout_d    = hit_limit && !done && owner_req;
                end
            end

            default: begin
                state_d      = IDLE;
                gnt_valid_d  = 1'b0;
                gnt_idx_d    = '0;
                gnt_onehot_d = '0;
                hold_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            hold_cnt_q   <= '0;
            gnt_valid_q  <= 1'b0;
            gnt_onehot_q <= '0;
            gnt_idx_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_onehot_q <= gnt_onehot_d;
            gnt_idx_q    <= gnt_idx_d;
            timeout_q    <= timeout_d;
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_onehot = gnt_onehot_q;
    assign gnt_idx    = gnt_idx_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8to3.sv
// Directed-vector bench for rr_arbiter_8to3: reset, single grant, rotation,
// pointer wrap, hold-limit timeout and reset during a grant.
module tb_rr_arbiter_8to3;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       gnt_valid;
    logic [7:0] gnt_onehot;
    logic [2:0] gnt_idx;
    logic       timeout;

    int unsigned n_checks;
    int unsigned n_fail;

    rr_arbiter_8to3 #(
        .MAX_HOLD(16),
        .HOLD_W  (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_onehot(gnt_onehot),
        .gnt_idx   (gnt_idx),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected one-hot is rebuilt from the expected index, not read from the DUT.
    task automatic check_outs(input string tag, input logic v, input logic [2:0] idx, input logic to);
        logic [7:0] oh;
        oh = v ? (8'd1 << idx) : 8'd0;
        check_eq({tag, ".valid"},   32'(gnt_valid),  32'(v));
        check_eq({tag, ".idx"},     32'(gnt_idx),    v ? 32'(idx) : 32'd0);
        check_eq({tag, ".onehot"},  32'(gnt_onehot), 32'(oh));
        check_eq({tag, ".timeout"}, 32'(timeout),    32'(to));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = 8'hFF;
        done     = 1'b0;

        // 1: reset with all requests pending
        tick(); tick(); tick();
        check_outs("t1_reset", 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_outs("t1_first", 1'b1, 3'd0, 1'b0);
        done = 1'b1;
        tick();
        check_outs("t1_rel", 1'b0, 3'd0, 1'b0);
        done = 1'b0;
        req  = 8'h00;
        tick();

        // 2: single requester 3, released by done in the 3rd grant cycle
        req = 8'b0000_1000;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_outs($sformatf("t2_c%0d", i), 1'b1, 3'd3, 1'b0);
        end
        done = 1'b1;
        tick();
        check_outs("t2_rel", 1'b0, 3'd0, 1'b0);
        done = 1'b0;
        req  = 8'h00;
        tick();

        // 3: full rotation with done asserted throughout
        do_reset();
        req  = 8'hFF;
        done = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_outs($sformatf("t3_g%0d", k), 1'b1, 3'(k % 8), 1'b0);
            tick();
            check_outs($sformatf("t3_i%0d", k), 1'b0, 3'd0, 1'b0);
        end
        done = 1'b0;
        req  = 8'h00;
        tick();

        // 4: pointer wrap from 7 to 0
        do_reset();
        req = 8'b0100_0000;
        tick();
        check_outs("t4_g6", 1'b1, 3'd6, 1'b0);
        req  = 8'b0100_0001;
        done = 1'b1;
        tick();
        check_outs("t4_rel6", 1'b0, 3'd0, 1'b0);
        done = 1'b0;
        tick();
        check_outs("t4_g0", 1'b1, 3'd0, 1'b0);
        done = 1'b1;
        tick();
        check_outs("t4_rel0", 1'b0, 3'd0, 1'b0);
        done = 1'b0;
        tick();
        check_outs("t4_g6b", 1'b1, 3'd6, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        tick();

        // 5: hold limit of 16 cycles forces release with timeout pulse
        req = 8'b0010_0000;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_outs($sformatf("t5_c%0d", i), 1'b1, 3'd5, 1'b0);
        end
        tick();
        check_outs("t5_timeout", 1'b0, 3'd0, 1'b1);
        tick();
        check_outs("t5_regrant", 1'b1, 3'd5, 1'b0);
        req = 8'h00;
        tick();
        check_outs("t5_dropreq", 1'b0, 3'd0, 1'b0);
        tick();
        check_outs("t5_idle", 1'b0, 3'd0, 1'b0);

        // 6: reset in the middle of a grant restores ptr to 0
        do_reset();
        req = 8'b0001_0000;
        tick();
        check_outs("t6_g4", 1'b1, 3'd4, 1'b0);
        rst_n = 1'b0;
        req   = 8'b0001_0001;
        tick();
        check_outs("t6_rst", 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_outs("t6_g0", 1'b1, 3'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
